adc_word_aligner: RTL and testbench

//   Parametrised multi-channel word aligner behind the dual-ISERDES DDR deserialisers.

---
 rtl/adc_word_aligner.sv | 198 +++++++++++++++++++
 tb/tb_adc_word_aligner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_word_aligner.sv
// Multi-channel word aligner: trains a common barrel-shift offset on the ADC
// frame word, tracks lock, and re-trains on loss of lock or on request.
module adc_word_aligner #(
    parameter int                 NUM_CH        = 4,
    parameter int                 WIDTH         = 12,
    parameter logic [WIDTH-1:0]   FRAME_PATTERN = 12'hFC0,
    parameter int                 LOCK_COUNT    = 16,
    parameter int                 SETTLE_CYCLES = 4,
    parameter int                 MAX_ERRS      = 3
) (
    input  logic                             CLKDIV,
    input  logic                             RSTN,
    input  logic                             IN_VALID,
    input  logic [WIDTH-1:0]                 FRAME_IN,
    input  logic [NUM_CH*WIDTH-1:0]          DATA_IN,
    input  logic                             RETRAIN,
    output logic [NUM_CH*WIDTH-1:0]          DATA_OUT,
    output logic                             OUT_VALID,
    output logic                             LOCKED,
    output logic [$clog2(WIDTH)-1:0]         SLIP_OFFSET,
    output logic                             TRAIN_FAIL,
    output logic                             LOCK_LOST
);

    localparam int KW = $clog2(WIDTH);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int TW = $clog2(SETTLE_CYCLES + 1);
    localparam int EW = $clog2(MAX_ERRS + 1);
    localparam int PW = $clog2(2 * WIDTH + 1);

    localparam logic [KW-1:0] K_MAX       = KW'(WIDTH - 1);
    localparam logic [MW-1:0] MATCH_LAST  = MW'(LOCK_COUNT - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [EW-1:0] ERR_LAST    = EW'(MAX_ERRS - 1);
    localparam logic [PW-1:0] SLIP_LIMIT  = PW'(2 * WIDTH);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SETTLE,
        ST_CONFIRM,
        ST_LOCK
    } state_t;

    state_t                    state, state_nxt;
    logic [KW-1:0]             k, k_nxt;
    logic [MW-1:0]             match_cnt, match_nxt;
    logic [TW-1:0]             settle_cnt, settle_nxt;
    logic [EW-1:0]             err_cnt, err_nxt;
    logic [PW-1:0]             slip_cnt, slip_nxt;
    logic                      fail, fail_nxt;
    logic                      lost_nxt;
    logic                      do_slip, do_lock;

    logic [WIDTH-1:0]          frame_prev;
    logic [NUM_CH*WIDTH-1:0]   data_prev;
    logic [2*WIDTH-1:0]        frame_cat, data_cat;
    logic [WIDTH-1:0]          frame_aligned;
    logic [NUM_CH*WIDTH-1:0]   data_aligned;
    logic                      is_match;

    // Barrel shift of {previous, current} word by the shared offset k.
    always_comb begin
        frame_cat     = {frame_prev, FRAME_IN};
        frame_aligned = frame_cat[k +: WIDTH];
        data_cat      = '0;
        data_aligned  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            data_cat = {data_prev[c*WIDTH +: WIDTH], DATA_IN[c*WIDTH +: WIDTH]};
            data_aligned[c*WIDTH +: WIDTH] = data_cat[k +: WIDTH];
        end
        is_match = (frame_aligned == FRAME_PATTERN);
    end

    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        match_nxt  = match_cnt;
        settle_nxt = settle_cnt;
        err_nxt    = err_cnt;
        slip_nxt   = slip_cnt;
        fail_nxt   = fail;
        lost_nxt   = 1'b0;
        do_slip    = 1'b0;
        do_lock    = 1'b0;

        if (RETRAIN) begin
            state_nxt  = ST_SEARCH;
            k_nxt      = '0;
            match_nxt  = '0;
            settle_nxt = '0;
            err_nxt    = '0;
            slip_nxt   = '0;
            fail_nxt   = 1'b0;
        end else if (IN_VALID) begin
            unique case (state)
                ST_SEARCH: begin
                    if (!is_match) begin
                        do_slip = 1'b1;
                    end else if (LOCK_COUNT <= 1) begin
                        do_lock = 1'b1;
                    end else begin
                        state_nxt = ST_CONFIRM;
                        match_nxt = MW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt >= SETTLE_LAST) begin
                        state_nxt  = ST_SEARCH;
                        settle_nxt = '0;
                    end else begin
                        settle_nxt = settle_cnt + 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    if (!is_match) begin
                        do_slip = 1'b1;
                    end else if (match_cnt >= MATCH_LAST) begin
                        do_lock = 1'b1;
                    end else begin
                        match_nxt = match_cnt + 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (is_match) begin
                        err_nxt = '0;
                    end else if (err_cnt >= ERR_LAST) begin
                        // Keep k: the link most likely still sits at the same offset.
                        state_nxt = ST_SEARCH;
                        err_nxt   = '0;
                        match_nxt = '0;
                        lost_nxt  = 1'b1;
                    end else begin
                        err_nxt = err_cnt + 1'b1;
                    end
                end
                default: state_nxt = ST_SEARCH;
            endcase

            if (do_slip) begin
                state_nxt  = ST_SETTLE;
                k_nxt      = (k == K_MAX) ? '0 : k + 1'b1;
                match_nxt  = '0;
                settle_nxt = '0;
                if (slip_cnt != SLIP_LIMIT) begin
                    slip_nxt = slip_cnt + 1'b1;
                end
                if (slip_nxt == SLIP_LIMIT) begin
                    fail_nxt = 1'b1;
                end
            end

            if (do_lock) begin
                state_nxt = ST_LOCK;
                match_nxt = '0;
                err_nxt   = '0;
                slip_nxt  = '0;
                fail_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLKDIV or negedge RSTN) begin
        if (!RSTN) begin
            state      <= ST_SEARCH;
            k          <= '0;
            match_cnt  <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            slip_cnt   <= '0;
            fail       <= 1'b0;
            LOCK_LOST  <= 1'b0;
            frame_prev <= '0;
            data_prev  <= '0;
            DATA_OUT   <= '0;
            OUT_VALID  <= 1'b0;
        end else begin
            state      <= state_nxt;
            k          <= k_nxt;
            match_cnt  <= match_nxt;
            settle_cnt <= settle_nxt;
            err_cnt    <= err_nxt;
            slip_cnt   <= slip_nxt;
            fail       <= fail_nxt;
            LOCK_LOST  <= lost_nxt;
            OUT_VALID  <= IN_VALID && (state == ST_LOCK);
            if (IN_VALID) begin
                frame_prev <= FRAME_IN;
                data_prev  <= DATA_IN;
                DATA_OUT   <= data_aligned;
            end
        end
    end

    assign LOCKED      = (state == ST_LOCK);
    assign SLIP_OFFSET = k;
    assign TRAIN_FAIL  = fail;

endmodule

// File: tb/tb_adc_word_aligner.sv
// Self-checking bench for adc_word_aligner: directed training scenarios with a
// scoreboard queue of expected aligned data words.
module tb_adc_word_aligner;

    localparam int W  = 12;
    localparam int NC = 4;
    localparam logic [W-1:0] FP = 12'hFC0;

    logic              CLKDIV = 1'b0;
    logic              RSTN = 1'b0;
    logic              IN_VALID = 1'b0;
    logic              RETRAIN = 1'b0;
    logic [W-1:0]      FRAME_IN = '0;
    logic [NC*W-1:0]   DATA_IN = '0;
    logic [NC*W-1:0]   DATA_OUT;
    logic              OUT_VALID;
    logic              LOCKED;
    logic [3:0]        SLIP_OFFSET;
    logic              TRAIN_FAIL;
    logic              LOCK_LOST;

    int                total = 0;
    int                bad = 0;
    int                wordIdx = 0;
    logic [NC*W-1:0]   expQ[$];
    logic [NC*W-1:0]   popped;

    adc_word_aligner #(
        .NUM_CH(NC), .WIDTH(W), .FRAME_PATTERN(FP),
        .LOCK_COUNT(16), .SETTLE_CYCLES(4), .MAX_ERRS(3)
    ) dut (
        .CLKDIV(CLKDIV), .RSTN(RSTN), .IN_VALID(IN_VALID),
        .FRAME_IN(FRAME_IN), .DATA_IN(DATA_IN), .RETRAIN(RETRAIN),
        .DATA_OUT(DATA_OUT), .OUT_VALID(OUT_VALID), .LOCKED(LOCKED),
        .SLIP_OFFSET(SLIP_OFFSET), .TRAIN_FAIL(TRAIN_FAIL), .LOCK_LOST(LOCK_LOST)
    );

    always #5 CLKDIV = ~CLKDIV;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Transmitted (correctly aligned) data word n of channel ch: a per-channel ramp.
    function automatic logic [W-1:0] alignedWord(input int n, input int ch);
        return W'((n * 7 + ch * 301 + 5) % 4096);
    endfunction

    function automatic logic [NC*W-1:0] alignedData(input int n);
        logic [NC*W-1:0] v;
        v = '0;
        for (int c = 0; c < NC; c++) v[c*W +: W] = alignedWord(n, c);
        return v;
    endfunction

    // Raw word seen by the aligner when the stream is skewed so that offset k recovers it.
    function automatic logic [W-1:0] rawOf(input logic [W-1:0] cur, input logic [W-1:0] nxt,
                                           input int k);
        logic [2*W-1:0] c;
        c = {cur, nxt};
        c = c >> (W - k);
        return c[W-1:0];
    endfunction

    function automatic logic [NC*W-1:0] rawData(input int n, input int k);
        logic [NC*W-1:0] v;
        v = '0;
        for (int c = 0; c < NC; c++) v[c*W +: W] = rawOf(alignedWord(n, c), alignedWord(n + 1, c), k);
        return v;
    endfunction

    // frameMode: 0 good frame, 1 frame corrupted in bit 0 of the aligned word, 2 all zeros
    task automatic applyStimulus(input int k, input int frameMode, input bit expectOut);
        logic [W-1:0] one;
        one = 1;
        IN_VALID = 1'b1;
        DATA_IN  = rawData(wordIdx, k);
        case (frameMode)
            0:       FRAME_IN = rawOf(FP, FP, k);
            1:       FRAME_IN = rawOf(FP, FP, k) ^ (one << k);
            default: FRAME_IN = '0;
        endcase
        if (expectOut) expQ.push_back(alignedData(wordIdx));
        wordIdx++;
        @(posedge CLKDIV);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic idleCycle();
        IN_VALID = 1'b0;
        @(posedge CLKDIV);
        #1;
    endtask

    task automatic resetDut();
        #2 RSTN = 1'b0;
        #3 RSTN = 1'b1;
        @(posedge CLKDIV);
        #1;
    endtask

    // Scoreboard: every OUT_VALID must consume exactly one expected word.
    always @(negedge CLKDIV) begin
        if (OUT_VALID === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_out_valid", OUT_VALID, 0);
            end else begin
                popped = expQ.pop_front();
                checkOutput("data_out", DATA_OUT, popped);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #7;
        checkOutput("reset_locked", LOCKED, 0);
        checkOutput("reset_out_valid", OUT_VALID, 0);
        checkOutput("reset_data_out", DATA_OUT, 0);
        checkOutput("reset_offset", SLIP_OFFSET, 0);
        checkOutput("reset_train_fail", TRAIN_FAIL, 0);
        checkOutput("reset_lock_lost", LOCK_LOST, 0);
        RSTN = 1'b1;
        @(posedge CLKDIV);
        #1;

        $display("[TB] scenario 1: aligned stream");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 0);
            if (i == 14) checkOutput("s1_not_locked_15", LOCKED, 0);
        end
        checkOutput("s1_locked_16", LOCKED, 1);
        checkOutput("s1_offset", SLIP_OFFSET, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1);
        idleCycle();
        checkOutput("s1_drained", expQ.size(), 0);

        $display("[TB] scenario 2: skewed stream, offset 5");
        resetDut();
        for (int i = 0; i < 41; i++) begin
            applyStimulus(5, 0, 0);
            if (i == 0)  checkOutput("s2_first_slip", SLIP_OFFSET, 1);
            if (i == 24) checkOutput("s2_offset_after_slips", SLIP_OFFSET, 5);
            if (i == 39) checkOutput("s2_not_locked", LOCKED, 0);
        end
        checkOutput("s2_locked", LOCKED, 1);
        checkOutput("s2_offset", SLIP_OFFSET, 5);
        for (int i = 0; i < 6; i++) applyStimulus(5, 0, 1);

        $display("[TB] scenario 3: frame errors while locked");
        applyStimulus(5, 1, 1);
        applyStimulus(5, 1, 1);
        applyStimulus(5, 0, 1);
        checkOutput("s3_still_locked", LOCKED, 1);
        checkOutput("s3_no_lost", LOCK_LOST, 0);
        applyStimulus(5, 1, 1);
        applyStimulus(5, 1, 1);
        checkOutput("s3_lost_not_yet", LOCK_LOST, 0);
        applyStimulus(5, 1, 1);
        checkOutput("s3_lock_lost", LOCK_LOST, 1);
        checkOutput("s3_unlocked", LOCKED, 0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(5, 0, 0);
            if (i == 0)  checkOutput("s3_lost_pulse_end", LOCK_LOST, 0);
            if (i == 14) checkOutput("s3_relock_pending", LOCKED, 0);
        end
        checkOutput("s3_relocked", LOCKED, 1);
        checkOutput("s3_offset_kept", SLIP_OFFSET, 5);
        for (int i = 0; i < 3; i++) applyStimulus(5, 0, 1);
        idleCycle();
        checkOutput("s3_drained", expQ.size(), 0);

        $display("[TB] scenario 4: dead frame channel");
        resetDut();
        for (int i = 0; i < 116; i++) begin
            applyStimulus(0, 2, 0);
            if (i == 114) checkOutput("s4_no_fail_23", TRAIN_FAIL, 0);
        end
        checkOutput("s4_fail_24", TRAIN_FAIL, 1);
        checkOutput("s4_offset_wrapped", SLIP_OFFSET, 0);
        checkOutput("s4_unlocked", LOCKED, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 2, 0);
        checkOutput("s4_search_continues", SLIP_OFFSET, 1);
        checkOutput("s4_fail_sticky", TRAIN_FAIL, 1);
        RETRAIN = 1'b1;
        @(posedge CLKDIV);
        #1;
        RETRAIN = 1'b0;
        checkOutput("s4_retrain_fail", TRAIN_FAIL, 0);
        checkOutput("s4_retrain_offset", SLIP_OFFSET, 0);
        checkOutput("s4_retrain_no_lost", LOCK_LOST, 0);

        $display("[TB] scenario 5: skewed stream with gaps");
        resetDut();
        for (int i = 0; i < 41; i++) begin
            applyStimulus(5, 0, 0);
            if (i == 39) checkOutput("s5_not_locked", LOCKED, 0);
            idleCycle();
        end
        checkOutput("s5_locked", LOCKED, 1);
        checkOutput("s5_offset", SLIP_OFFSET, 5);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(5, 0, 1);
            idleCycle();
        end
        checkOutput("s5_gap_locked", LOCKED, 1);
        idleCycle();
        checkOutput("s5_drained", expQ.size(), 0);

        $display("[TB] scenario 6: async reset while locked");
        #2 RSTN = 1'b0;
        #1;
        checkOutput("s6_rst_locked", LOCKED, 0);
        checkOutput("s6_rst_data", DATA_OUT, 0);
        checkOutput("s6_rst_offset", SLIP_OFFSET, 0);
        checkOutput("s6_rst_out_valid", OUT_VALID, 0);
        #2 RSTN = 1'b1;
        @(posedge CLKDIV);
        #1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 0);
            if (i == 14) checkOutput("s6_not_locked", LOCKED, 0);
        end
        checkOutput("s6_locked", LOCKED, 1);
        checkOutput("s6_offset", SLIP_OFFSET, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1);
        idleCycle();
        idleCycle();
        checkOutput("s6_drained", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
